// File: rtl/seq_mult_nbit.sv
//
// seq_mult_nbit
// -------------
// Multicycle N x N multiplier with valid/ready handshakes on both sides.
// The multiplier operand is retired K bits per clock: each BUSY cycle adds
// one K x N partial product, shifted into place, to a 2N-bit accumulator.
// An operation therefore takes N/K cycles from accept to result.
//
// Optional feature (macro SEQ_MULT_SIGNED_EN):
//   defined   - adds the 'sgn' input; sgn=1 treats a and b as two's
//               complement and produces a two's-complement product, sgn=0
//               is plain unsigned. Operands are converted to magnitudes on
//               accept and the result is negated on completion.
//   undefined - unsigned only, no 'sgn' port, no negation logic.
//
// Parameters:
//   N  operand width (multiple of K, N >= 4)
//   K  multiplier bits retired per cycle (1, 2, 4 or 8)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a, b (and sgn) are valid
//   in_ready   block accepts operands this cycle
//   a          multiplicand, N bits
//   b          multiplier, N bits
//   sgn        signed operation select (SEQ_MULT_SIGNED_EN only)
//   out_valid  product is valid
//   out_ready  consumer accepts the product this cycle
//   product    full 2N-bit product
//
// in_ready is the only combinational input-to-output path: in DONE it
// follows out_ready so a new operation can be accepted in the same cycle
// the old result is consumed.

module seq_mult_nbit #(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic           sgn,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product
);

    localparam int DIGITS = N / K;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;

    logic            accept;
    logic            step;
    logic            last_digit;

    logic [N-1:0]    mcand;
    logic [N-1:0]    mplier;
    logic [N-1:0]    mcand_in;
    logic [N-1:0]    mplier_in;
    logic [CW-1:0]   count;
    logic [K-1:0]    digit;
    logic [2*N-1:0]  acc;
    logic [2*N-1:0]  partial;
    logic [2*N-1:0]  acc_next;
    logic [2*N-1:0]  result;

`ifdef SEQ_MULT_SIGNED_EN
    logic            neg_a;
    logic            neg_b;
    logic            res_neg;

    // Operands are stored as magnitudes so the digit loop is always
    // unsigned. -2^(N-1) maps to 2^(N-1), which still fits in N unsigned
    // bits, so no extra width is needed.
    always_comb begin
        neg_a     = sgn & a[N-1];
        neg_b     = sgn & b[N-1];
        mcand_in  = neg_a ? -a : a;
        mplier_in = neg_b ? -b : b;
    end
`else
    // Unsigned-only build: operands are latched as-is.
    always_comb begin
        mcand_in  = a;
        mplier_in = b;
    end
`endif

    // One digit of the multiplier per cycle. The digit is picked by the
    // counter rather than by shifting the multiplier register, so the
    // latched operand stays intact for the whole operation. The partial
    // product is formed at full accumulator width and shifted to its
    // digit position before being added in.
    always_comb begin
        digit      = K'(mplier >> (K * count));
        partial    = ({{N{1'b0}}, mcand} * {{(2*N-K){1'b0}}, digit}) << (K * count);
        acc_next   = acc + partial;
        last_digit = (count == LAST_DIGIT);
`ifdef SEQ_MULT_SIGNED_EN
        result     = res_neg ? -acc_next : acc_next;
`else
        result     = acc_next;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake logic. From DONE a consumed result and a
    // waiting operand pair are handled on the same edge, which is what
    // lets back-to-back operations proceed without an idle bubble.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        accept     = 1'b1;
                        state_next = BUSY;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. The product register is written only when the last digit
    // is retired, so it holds the previous result throughout the next
    // operation and stays stable while the consumer applies backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            res_neg <= 1'b0;
`endif
        end else if (accept) begin
            mcand   <= mcand_in;
            mplier  <= mplier_in;
            acc     <= '0;
            count   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            res_neg <= sgn & (a[N-1] ^ b[N-1]);
`endif
        end else if (step) begin
            acc   <= acc_next;
            count <= count + CW'(1);
            if (last_digit) begin
                product <= result;
            end
        end
    end

endmodule
